// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding RISC-V load/store unit in front of the
//                mmu. Checks funct3 and alignment, drives the mmu request for
//                one ISSUE cycle, waits for mem_ready, then returns one
//                response. It does its own load lane extraction and extension.
//                Optional macro LSU_TIMEOUT_EN aborts a WAIT that lasts
//                TIMEOUT_CYCLES cycles without mem_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic        mem_signed_read,
    output logic [1:0]  mem_data_width,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] maddr_q, maddr_d;
    logic [1:0]  mwidth_q, mwidth_d;
    logic [31:0] mdata_q, mdata_d;

    logic        w_legal;
    logic        w_misaligned;
    logic [1:0]  w_store_width;

    // Picks the addressed byte/half out of the fetched word and extends it.
    function automatic logic [31:0] extract(input logic [31:0] data,
                                            input logic [1:0]  lane,
                                            input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{lane, 3'b000} +: 8];
        h = data[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'h0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'h0, h};
            default: extract = data;
        endcase
    endfunction

    // Request decode: loads allow 000/001/010/100/101, stores 000/001/010.
    always_comb begin
        if (req_is_store) begin
            w_legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
        end else begin
            w_legal = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
        end
        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
        w_store_width = {req_funct3[1], req_funct3[1] | req_funct3[0]};
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // WAIT-cycle counter for the mmu timeout.
    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state and next-value logic of the request FSM.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        lane_d     = lane_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        maddr_d    = maddr_q;
        mwidth_d   = mwidth_q;
        mdata_d    = mdata_q;
`ifdef LSU_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    lane_d     = req_address[1:0];
                    rdata_d    = 32'h0;
                    err_d      = !w_legal || w_misaligned;
                    if (!w_legal || w_misaligned) begin
                        // Rejected requests never reach the mmu.
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                        if (req_is_store) begin
                            maddr_d  = req_address;
                            mwidth_d = w_store_width;
                            mdata_d  = req_wdata;
                        end else begin
                            maddr_d  = {req_address[31:2], 2'b00};
                            mwidth_d = 2'd3;
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef LSU_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            WAIT: begin
                if (mem_ready) begin
                    rdata_d = is_store_q ? 32'h0 : extract(mem_data_out, lane_q, funct3_q);
                    state_d = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b0;
            lane_q     <= 2'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            maddr_q    <= 32'h0;
            mwidth_q   <= 2'd3;
            mdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            lane_q     <= lane_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            maddr_q    <= maddr_d;
            mwidth_q   <= mwidth_d;
            mdata_q    <= mdata_d;
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign resp_valid       = (state_q == RESP);
    assign resp_error       = (state_q == RESP) && err_q;
    assign resp_rdata       = (state_q == RESP) ? rdata_q : 32'h0;
    assign mem_read_enable  = (state_q == ISSUE) && !is_store_q;
    assign mem_write_enable = (state_q == ISSUE) && is_store_q;
    assign mem_signed_read  = 1'b0;
    assign mem_data_width   = mwidth_q;
    assign mem_address      = maddr_q;
    assign mem_data_in      = mdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit with a small mmu
//                responder and a word-array reference model. Honours
//                LSU_TIMEOUT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic        mem_signed_read;
    logic [1:0]  mem_data_width;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_ready;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_funct3       (req_funct3),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_signed_read  (mem_signed_read),
        .mem_data_width   (mem_data_width),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .mem_ready        (mem_ready)
    );

    always #5 clk = ~clk;

    // ---------------- mmu responder ----------------
    logic [31:0] mmu_mem [16];
    bit          mem_inited = 1'b0;
    logic        rmw_busy;
    logic        hold_off;
    int          en_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] iss_addr;
    logic [1:0]  iss_width;
    logic [31:0] iss_data;

    assign mem_ready    = !rmw_busy && !hold_off;
    assign mem_data_out = mmu_mem[mem_address[5:2]];

    always @(posedge clk) begin
        if (reset) begin
            rmw_busy <= 1'b0;
            if (!mem_inited) begin
                for (int i = 0; i < 16; i++) mmu_mem[i] <= 32'h0;
                mem_inited <= 1'b1;
            end
        end else begin
            // Sub-word writes cost the mmu one extra read-modify-write cycle.
            rmw_busy <= mem_write_enable && (mem_data_width != 2'd3);
            if (mem_write_enable) begin
                case (mem_data_width)
                    2'd0:    mmu_mem[mem_address[5:2]][{mem_address[1:0], 3'b000} +: 8] <= mem_data_in[7:0];
                    2'd1:    mmu_mem[mem_address[5:2]][{mem_address[1], 4'b0000} +: 16] <= mem_data_in[15:0];
                    default: mmu_mem[mem_address[5:2]] <= mem_data_in;
                endcase
            end
        end
        if (mem_read_enable || mem_write_enable) begin
            en_cnt    <= en_cnt + 1;
            iss_addr  <= mem_address;
            iss_width <= mem_data_width;
            iss_data  <= mem_data_in;
        end
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] ref_mem [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One request end to end; hold = cycles mem_ready is held low after ISSUE.
    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold);
        bit          legal, bad, e_err;
        int          sz, e_lat, cyc, en0, sh;
        logic [31:0] word, v, e_rd, e_addr, mask;
        logic [1:0]  e_w;

        sz    = 1 << f3[1:0];
        legal = st ? (f3 < 3) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        bad   = !legal || ((a % sz) != 0);
        e_err = bad;
        e_rd  = 32'h0;
        word  = ref_mem[a[5:2]];
        sh    = 8 * int'(a % 4);
        if (bad) begin
            e_lat = 1;
        end else if (st) begin
            e_lat = (sz == 4) ? 3 : 4;
            mask  = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
            ref_mem[a[5:2]] = (word & ~(mask << sh)) | ((wd & mask) << sh);
        end else begin
            e_lat = 3 + hold;
            v = word >> sh;
            if (sz == 1) begin
                v = v & 32'hFF;
                if (!f3[2] && v >= 128) v = v - 32'd256;
            end else if (sz == 2) begin
                v = v & 32'hFFFF;
                if (!f3[2] && v >= 32768) v = v - 32'd65536;
            end
            e_rd = v;
        end
`ifdef LSU_TIMEOUT_EN
        if (!bad && hold >= TMO) begin
            e_lat = 2 + TMO;
            e_err = 1'b1;
            e_rd  = 32'h0;
        end
`endif
        e_addr = st ? a : (a & ~32'h3);
        e_w    = st ? 2'(sz - 1) : 2'd3;

        @(negedge clk);
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_address  = a;
        req_wdata    = wd;
        hold_off     = (hold > 0);
        en0          = en_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 1;
        while (1) begin
            if (hold > 0 && cyc == 2 + hold) hold_off = 1'b0;
            if (resp_valid || cyc >= 100) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", cyc, e_lat);
        chk("resp_error", {31'h0, resp_error}, {31'h0, e_err});
        chk("resp_rdata", resp_rdata, e_rd);
        chk("issue_count", en_cnt - en0, bad ? 0 : 1);
        if (!bad) begin
            chk("issue_addr", iss_addr, e_addr);
            chk("issue_width", {30'h0, iss_width}, {30'h0, e_w});
            chk("addr_stable", mem_address, e_addr);
            if (st) chk("issue_wdata", iss_data, wd);
        end
        hold_off = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        int rc0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b0;
        req_address  = 32'h0;
        req_wdata    = 32'h0;
        hold_off     = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
        chk("rst_enables", {30'h0, mem_read_enable, mem_write_enable}, 32'h0);
        chk("rst_signed", {31'h0, mem_signed_read}, 32'h0);
        chk("rst_width", {30'h0, mem_data_width}, 32'h3);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_data_in", mem_data_in, 32'h0);

        // Word load
        do_req(1'b1, 3'b010, 32'h0100_0010, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 3'b010, 32'h0100_0010, 32'h0, 0);
        // Byte/half extraction and extension
        do_req(1'b1, 3'b010, 32'h0100_0010, 32'h80FF_7F01, 0);
        do_req(1'b0, 3'b000, 32'h0100_0013, 32'h0, 0);
        do_req(1'b0, 3'b100, 32'h0100_0013, 32'h0, 0);
        do_req(1'b0, 3'b001, 32'h0100_0012, 32'h0, 0);
        do_req(1'b0, 3'b101, 32'h0100_0012, 32'h0, 0);
        // Byte store through the mmu read-modify-write
        do_req(1'b1, 3'b010, 32'h0100_0010, 32'h1122_3344, 0);
        do_req(1'b1, 3'b000, 32'h0100_0011, 32'h0000_00AA, 0);
        do_req(1'b0, 3'b010, 32'h0100_0010, 32'h0, 0);
        // Rejected requests
        do_req(1'b0, 3'b010, 32'h0100_0012, 32'h0, 0);
        do_req(1'b0, 3'b001, 32'h0100_0011, 32'h0, 0);
        do_req(1'b0, 3'b011, 32'h0100_0010, 32'h0, 0);
        // mmu stalls 40 cycles
        do_req(1'b0, 3'b010, 32'h0100_0010, 32'h0, 40);

        // Reset during WAIT
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'b010;
        req_address  = 32'h0100_0010;
        hold_off     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rc0   = resp_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("midrst_enables", {30'h0, mem_read_enable, mem_write_enable}, 32'h0);
        chk("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("midrst_addr", mem_address, 32'h0);
        chk("midrst_width", {30'h0, mem_data_width}, 32'h3);
        hold_off = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_resp", resp_cnt - rc0, 32'h0);
        do_req(1'b0, 3'b010, 32'h0100_0010, 32'h0, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom % 2), 3'($urandom % 8),
                   32'h0100_0000 | ($urandom % 64), $urandom, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
